// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path types and constants
package audio_pkg;

  localparam int SAMPLE_WIDTH_DEFAULT = 16;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-bit input synchronizer with rising-edge pulse on bit 0
module sync_edge_detect #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             rise_o
);

  // Left unreset so a reset pulse cannot fake an edge or an lrclk transition.
  logic [WIDTH-1:0] chain_q [SYNC_STAGES];
  logic             prev_q;

  always_ff @(posedge clk) begin
    chain_q[0] <= d_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      chain_q[i] <= chain_q[i-1];
    end
    prev_q <= chain_q[SYNC_STAGES-1][0];
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1][0] & ~prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S slave deserializer producing stereo sample pairs
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bclk,
  input  logic                           lrclk,
  input  logic                           adcdat,
  output logic signed [SAMPLE_WIDTH-1:0] leftSampleOut,
  output logic signed [SAMPLE_WIDTH-1:0] rightSampleOut,
  output logic                           sampleValid,
  output logic                           frameError
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  logic [2:0] sync_vec;
  logic       bit_tick;
  logic       lr_sync;
  logic       dat_sync;

  sync_edge_detect #(
    .WIDTH      (3),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .d_i   ({adcdat, lrclk, bclk}),
    .sync_o(sync_vec),
    .rise_o(bit_tick)
  );

  assign lr_sync  = sync_vec[1];
  assign dat_sync = sync_vec[2];

  i2s_rx_state_t           state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    lr_prev_q, lr_prev_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    boundary;
  logic                    full;

  assign boundary = lr_sync ^ lr_prev_q;
  assign full     = (count_q == CW'(SAMPLE_WIDTH));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    lr_prev_d = lr_prev_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (bit_tick) begin
      lr_prev_d = lr_sync;
      // The boundary tick carries the I2S delay bit, so it is never shifted.
      if (boundary) begin
        count_d = '0;
      end else if (state_q != WAIT_SYNC && !full) begin
        shift_d = {shift_q[SAMPLE_WIDTH-2:0], dat_sync};
        count_d = count_q + CW'(1);
      end
      case (state_q)
        WAIT_SYNC: begin
          if (boundary && !lr_sync) state_d = LEFT;
        end
        LEFT: begin
          if (boundary) begin
            if (lr_sync && full) begin
              hold_d  = shift_q;
              state_d = RIGHT;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_SYNC;
            end
          end
        end
        RIGHT: begin
          if (boundary) begin
            if (!lr_sync && full) begin
              left_d  = hold_q;
              right_d = shift_q;
              valid_d = 1'b1;
              state_d = LEFT;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_SYNC;
            end
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_SYNC;
      count_q   <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      lr_prev_q <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      lr_prev_q <= lr_prev_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign leftSampleOut  = left_q;
  assign rightSampleOut = right_q;
  assign sampleValid    = valid_q;
  assign frameError     = err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - randomized scoreboard bench for i2s_receiver
`timescale 1ns/1ps
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b1;
  logic        adcdat = 1'b0;
  logic [15:0] l_out;
  logic [15:0] r_out;
  logic        sv;
  logic        fe;

  i2s_receiver #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .adcdat        (adcdat),
    .leftSampleOut (l_out),
    .rightSampleOut(r_out),
    .sampleValid   (sv),
    .frameError    (fe)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] l;
    logic [15:0] r;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  n_valid = 0;

  // Slot-level reference: a slot is judged when the opposite lrclk level begins.
  bit          m_synced;
  bit          m_lr;
  int          m_len;
  int          m_nvalid = 0;
  logic [15:0] m_word, m_left, m_hold_l, m_hold_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_synced = 1'b0;
    m_lr     = 1'b1;
    m_len    = 0;
    m_word   = '0;
    m_left   = '0;
    m_hold_l = '0;
    m_hold_r = '0;
  endfunction

  function automatic void model_slot(input bit lr, input logic [15:0] w, input int nbits);
    bit was;
    if (lr != m_lr) begin
      was = m_synced;
      if (m_synced) begin
        if (m_len < 16) begin
          exp_q.push_back('{1'b1, m_hold_l, m_hold_r});
          m_synced = 1'b0;
        end else if (lr) begin
          m_left = m_word;
        end else begin
          m_hold_l = m_left;
          m_hold_r = m_word;
          exp_q.push_back('{1'b0, m_hold_l, m_hold_r});
          m_nvalid++;
        end
      end
      if (!was && !lr) m_synced = 1'b1;
    end
    m_lr   = lr;
    m_word = w;
    m_len  = nbits;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_left", {16'h0, l_out}, 32'h0);
    check("reset_right", {16'h0, r_out}, 32'h0);
    check("reset_valid", {31'h0, sv}, 32'h0);
  endtask

  // Bit 0 of a slot is the delay bit; bits 1..16 carry the word MSB first.
  task automatic send_slot(input bit lr, input logic [15:0] w, input int len, input int rst_at);
    logic d;
    model_slot(lr, w, len - 1);
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= 16) d = w[16-i];
      else d = 1'($urandom);
      bclk   = 1'b0;
      lrclk  = lr;
      adcdat = d;
      #163;
      if (i == rst_at) do_reset();
      bclk = 1'b1;
      #163;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32, -1);
    send_slot(1'b1, r, 32, -1);
  endtask

  always @(negedge clk) begin
    if (!reset && (sv || fe)) begin
      if (sv) n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0d error=%0d expected no pulse at %0t", sv, fe, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'h0, sv, fe}, mon_e.is_err ? 32'h1 : 32'h2);
        check("left_sample", {16'h0, l_out}, {16'h0, mon_e.l});
        check("right_sample", {16'h0, r_out}, {16'h0, mon_e.r});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    int          waited;
    model_reset();
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("por_left", {16'h0, l_out}, 32'h0);
    check("por_right", {16'h0, r_out}, 32'h0);
    check("por_valid", {31'h0, sv}, 32'h0);
    check("por_error", {31'h0, fe}, 32'h0);

    // Stream joins mid right slot.
    send_slot(1'b1, 16'($urandom), 20, -1);
    send_frame(16'h8001, 16'h7FFE);
    for (int n = 1; n <= 10; n++) send_frame(16'(n), 16'(-n));

    // Truncated left slot, then recovery.
    send_slot(1'b0, 16'($urandom), 13, -1);
    send_slot(1'b1, 16'($urandom), 32, -1);
    send_frame(16'h1234, 16'hABCD);

    // Reset in the middle of a right slot.
    send_slot(1'b0, 16'h5A5A, 32, -1);
    send_slot(1'b1, 16'hA5A5, 32, 10);
    send_frame(16'h0F0F, 16'hF0F0);

    // Zero-length left slot.
    send_slot(1'b0, 16'h1111, 1, -1);
    send_slot(1'b1, 16'h2222, 32, -1);
    send_frame(16'hFFFF, 16'h0000);

    // bclk phase sweep against clk.
    for (int k = 0; k < 8; k++) begin
      #(k);
      a = 16'($urandom);
      b = 16'($urandom);
      send_frame(a, b);
    end

    // Start of a further left slot closes the last right slot.
    send_slot(1'b0, 16'h0, 2, -1);
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    repeat (20) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("valid_count", 32'(n_valid), 32'(m_nvalid));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
